vga_frame_capture: RTL and testbench

- Receive-side counterpart of the VGA sync/pixel generator. It consumes the generator's o_hsync/o_vsync/o_blue stream on the same pixel clock.
- Reconstructs the pixel coordinates from the sync edges and extracts the 299x299 image window.
- Writes each window pixel into frame-buffer memory at the same word addresses the generator reads from. This gives closed-loop frame readback for verification and for the CPU's screenshot path.

---
 rtl/vga_frame_capture_pkg.sv | 33 +++
 rtl/vga_frame_capture_if.sv | 30 +++
 rtl/vga_frame_capture_sync_tracker.sv | 95 +++++++++
 rtl/vga_frame_capture.sv | 140 ++++++++++++++
 tb/tb_vga_frame_capture.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_frame_capture_pkg.sv
// Shared timing constants and types for the VGA frame-capture block.
// Default values describe the 299x299 window written from word address 25.
package vga_pkg;

    localparam int H_TOTAL   = 800;
    localparam int X_MIN     = 201;
    localparam int X_MAX     = 499;
    localparam int Y_MIN     = 101;
    localparam int Y_MAX     = 399;
    localparam int DATA_LAT  = 1;
    localparam int ADDR_BASE = 25;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CAPTURE,
        DONE
    } cap_state_t;

    typedef logic [7:0]     pixel_t;
    typedef logic [X_W-1:0] xcnt_t;
    typedef logic [Y_W-1:0] ycnt_t;

    function automatic logic in_range(input logic [X_W-1:0] v,
                                      input logic [X_W-1:0] lo,
                                      input logic [X_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// Video stream in, frame-buffer write bus out; the source side is the master.
interface vga_frame_capture_if;
    import vga_pkg::*;

    logic        i_hsync;
    logic        i_vsync;
    pixel_t      i_blue;
    logic        o_wr_en;
    logic [31:0] o_wr_addr;
    pixel_t      o_wr_data;

    modport master (
        output i_hsync,
        output i_vsync,
        output i_blue,
        input  o_wr_en,
        input  o_wr_addr,
        input  o_wr_data
    );

    modport slave (
        input  i_hsync,
        input  i_vsync,
        input  i_blue,
        output o_wr_en,
        output o_wr_addr,
        output o_wr_data
    );

endinterface

// File: rtl/vga_frame_capture_sync_tracker.sv
// Sync edge detection and local x/y reconstruction for the capture path.
// Line-length checker is built only with VGA_CAPTURE_SYNC_CHECK_EN defined.
module vga_sync_tracker
    import vga_pkg::*;
#(
    parameter int P_H_TOTAL = H_TOTAL
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_hsync,
    input  logic  i_vsync,
    output xcnt_t o_x,
    output ycnt_t o_y,
    output logic  o_h_rise,
    output logic  o_v_rise,
    output logic  o_sync_err
);

    localparam xcnt_t X_LAST = xcnt_t'(P_H_TOTAL - 1);
    localparam ycnt_t Y_SAT  = '1;

    logic [1:0] w_sync_in;
    logic [1:0] r_sync_q;
    logic [1:0] w_rise;
    xcnt_t      r_x;
    ycnt_t      r_y;

    assign w_sync_in = {i_vsync, i_hsync};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_q <= '0;
        end else begin
            r_sync_q <= w_sync_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            assign w_rise[gi] = w_sync_in[gi] & ~r_sync_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
        end else if (w_rise[0]) begin
            r_x <= xcnt_t'(1);
        end else if (r_x == X_LAST) begin
            r_x <= '0;
        end else begin
            r_x <= r_x + 1'b1;
        end
    end

    // Frame sync has priority over line sync when both rise together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= '0;
        end else if (w_rise[1]) begin
            r_y <= '0;
        end else if (w_rise[0] && (r_y != Y_SAT)) begin
            r_y <= r_y + 1'b1;
        end
    end

`ifdef VGA_CAPTURE_SYNC_CHECK_EN
    logic r_seen_h;
    logic r_sync_err;

    // On a correct-length line x has just wrapped from H_TOTAL-1 to 0 when hsync rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen_h   <= 1'b0;
            r_sync_err <= 1'b0;
        end else if (w_rise[0]) begin
            r_seen_h <= 1'b1;
            if (r_seen_h && (r_x != '0)) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    assign o_sync_err = r_sync_err;
`else
    assign o_sync_err = 1'b0;
`endif

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_h_rise = w_rise[0];
    assign o_v_rise = w_rise[1];

endmodule

// File: rtl/vga_frame_capture.sv
// Captures the image window of a VGA stream into frame-buffer word writes.
// Optional line-length checker: define VGA_CAPTURE_SYNC_CHECK_EN.
module vga_frame_capture
    import vga_pkg::*;
#(
    parameter int P_H_TOTAL   = H_TOTAL,
    parameter int P_X_MIN     = X_MIN,
    parameter int P_X_MAX     = X_MAX,
    parameter int P_Y_MIN     = Y_MIN,
    parameter int P_Y_MAX     = Y_MAX,
    parameter int P_DATA_LAT  = DATA_LAT,
    parameter int P_ADDR_BASE = ADDR_BASE
) (
    input  logic                VGA_CLK_IN,
    input  logic                VGA_RST_N,
    vga_frame_capture_if.slave  vif,
    input  logic                i_arm,
    input  logic                i_continuous,
    output logic                o_busy,
    output logic                o_frame_done,
    output logic                o_sync_err
);

    localparam xcnt_t       X_LO   = xcnt_t'(P_X_MIN);
    localparam xcnt_t       X_HI   = xcnt_t'(P_X_MAX);
    localparam xcnt_t       Y_LO   = xcnt_t'(P_Y_MIN);
    localparam xcnt_t       Y_HI   = xcnt_t'(P_Y_MAX);
    localparam ycnt_t       Y_LAST = ycnt_t'(P_Y_MAX);
    localparam logic [31:0] A_BASE = 32'(P_ADDR_BASE);

    xcnt_t       w_x;
    ycnt_t       w_y;
    logic        w_h_rise;
    logic        w_v_rise;
    xcnt_t       w_xd;
    logic        w_hit;
    logic        w_last_px;

    cap_state_t  r_state;
    cap_state_t  w_state_next;
    logic        w_capture_wr;
    logic        w_restart;

    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    pixel_t      r_wr_data;
    logic [31:0] r_next_addr;
    logic        r_last_wr;

    vga_sync_tracker #(
        .P_H_TOTAL (P_H_TOTAL)
    ) u_tracker (
        .clk        (VGA_CLK_IN),
        .rst_n      (VGA_RST_N),
        .i_hsync    (vif.i_hsync),
        .i_vsync    (vif.i_vsync),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_h_rise   (w_h_rise),
        .o_v_rise   (w_v_rise),
        .o_sync_err (o_sync_err)
    );

    // Unsigned 11-bit subtract: x < DATA_LAT wraps high and falls outside the window.
    assign w_xd      = w_x - xcnt_t'(P_DATA_LAT);
    assign w_hit     = in_range(w_xd, X_LO, X_HI) && in_range({1'b0, w_y}, Y_LO, Y_HI);
    assign w_last_px = (w_xd == X_HI) && (w_y == Y_LAST);

    always_ff @(posedge VGA_CLK_IN or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture_wr = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_arm) begin
                    w_state_next = SYNC;
                end
            end
            SYNC: begin
                if (w_v_rise) begin
                    w_state_next = CAPTURE;
                    w_restart    = 1'b1;
                end
            end
            CAPTURE: begin
                // Stay here while the final write is on the bus, so writes never leave CAPTURE.
                if (w_v_rise) begin
                    w_state_next = SYNC;
                    w_restart    = 1'b1;
                end else if (r_last_wr) begin
                    w_state_next = DONE;
                end else begin
                    w_capture_wr = w_hit;
                end
            end
            DONE: begin
                w_state_next = i_continuous ? SYNC : IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge VGA_CLK_IN or negedge VGA_RST_N) begin
        if (!VGA_RST_N) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= A_BASE;
            r_wr_data   <= '0;
            r_next_addr <= A_BASE;
            r_last_wr   <= 1'b0;
        end else begin
            r_wr_en   <= w_capture_wr;
            r_last_wr <= w_capture_wr && w_last_px;
            if (w_restart) begin
                r_wr_addr   <= A_BASE;
                r_next_addr <= A_BASE;
            end else if (w_capture_wr) begin
                r_wr_addr   <= r_next_addr;
                r_wr_data   <= vif.i_blue;
                r_next_addr <= r_next_addr + 32'd1;
            end
        end
    end

    assign vif.o_wr_en   = r_wr_en;
    assign vif.o_wr_addr = r_wr_addr;
    assign vif.o_wr_data = r_wr_data;
    assign o_busy        = (r_state == SYNC) || (r_state == CAPTURE);
    assign o_frame_done  = (r_state == DONE);

endmodule

// File: tb/tb_vga_frame_capture.sv
// Self-checking bench for vga_frame_capture with a reduced raster so whole frames fit.
module tb_vga_frame_capture;
    import vga_pkg::*;

    localparam int TH        = 262;
    localparam int TXMIN     = 201;
    localparam int TXMAX     = 260;
    localparam int TYMIN     = 3;
    localparam int TYMAX     = 5;
    localparam int TLAT      = 1;
    localparam int TBASE     = 25;
    localparam int TV        = 8;
    localparam int HS_W      = 32;
    localparam int PER_FRAME = (TXMAX - TXMIN + 1) * (TYMAX - TYMIN + 1);
    localparam int RST_COL   = 230;
`ifdef VGA_CAPTURE_SYNC_CHECK_EN
    localparam bit EXP_SYNC_ERR = 1'b1;
`else
    localparam bit EXP_SYNC_ERR = 1'b0;
`endif

    logic VGA_CLK_IN   = 1'b0;
    logic VGA_RST_N    = 1'b0;
    logic i_arm        = 1'b0;
    logic i_continuous = 1'b0;
    logic o_busy;
    logic o_frame_done;
    logic o_sync_err;

    vga_frame_capture_if vif ();

    vga_frame_capture #(
        .P_H_TOTAL   (TH),
        .P_X_MIN     (TXMIN),
        .P_X_MAX     (TXMAX),
        .P_Y_MIN     (TYMIN),
        .P_Y_MAX     (TYMAX),
        .P_DATA_LAT  (TLAT),
        .P_ADDR_BASE (TBASE)
    ) dut (
        .VGA_CLK_IN   (VGA_CLK_IN),
        .VGA_RST_N    (VGA_RST_N),
        .vif          (vif),
        .i_arm        (i_arm),
        .i_continuous (i_continuous),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_sync_err   (o_sync_err)
    );

    always #5 VGA_CLK_IN = ~VGA_CLK_IN;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        bit cont;
        int n_cap;
        int inject_line;
        int exp_done;
        int exp_writes;
    } vec_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          n_done   = 0;
    int          rst_writes = 0;
    bit          first_seen = 0;
    logic [31:0] first_addr, last_addr;
    logic [7:0]  first_data, last_data;
    logic        done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard side: every write on the bus must match the oldest expected entry.
    always @(negedge VGA_CLK_IN) begin
        wr_t e;
        if (vif.o_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write actual=addr %0d required=no write", vif.o_wr_addr);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", vif.o_wr_addr, e.addr);
                check("wr_data", 32'(vif.o_wr_data), 32'(e.data));
            end
            n_writes++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_addr = vif.o_wr_addr;
                first_data = vif.o_wr_data;
            end
            last_addr = vif.o_wr_addr;
            last_data = vif.o_wr_data;
        end
        if (o_frame_done === 1'b1) begin
            n_done++;
            check("done_after_last_write", 32'(exp_q.size()), 32'd0);
            check("done_width", 32'(done_prev), 32'd0);
        end
        done_prev <= o_frame_done;
    end

    // Source model: col numbers each cycle the way the capture's x will count it,
    // and i_blue carries the pixel of column col-TLAT.
    task automatic run_frame(input bit cap, input bit arm, input int inject_line,
                             input int rst_line, input int short_line);
        int  addr;
        int  len;
        int  px;
        bit  active;
        addr   = TBASE;
        active = cap;
        for (int l = 0; l < TV; l++) begin
            len = (l == short_line) ? TH - 10 : TH;
            if (l == inject_line) active = 1'b0;
            for (int c = 0; c < len; c++) begin
                @(posedge VGA_CLK_IN);
                #1;
                vif.i_hsync = (c < HS_W);
                vif.i_vsync = (l < 2) || (l == inject_line);
                px = c - TLAT;
                vif.i_blue = 8'(px);
                if (arm && l == 2 && c == 0) i_arm = 1'b1;
                if (arm && l == 3 && c == 0) i_arm = 1'b0;
                if (active && l >= TYMIN && l <= TYMAX && px >= TXMIN && px <= TXMAX) begin
                    exp_q.push_back('{addr: 32'(addr), data: 8'(px)});
                    addr++;
                end
                if (l == rst_line && c == RST_COL) begin
                    #2;
                    VGA_RST_N = 1'b0;
                    #1;
                    check("async_rst_wr_en", 32'(vif.o_wr_en), 32'd0);
                    check("async_rst_wr_addr", vif.o_wr_addr, 32'(TBASE));
                    check("async_rst_busy", 32'(o_busy), 32'd0);
                    exp_q.delete();
                    active     = 1'b0;
                    rst_writes = n_writes;
                end
                if (l == rst_line + 1 && c == 100) VGA_RST_N = 1'b1;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int d0;
        int w0;
        d0 = n_done;
        w0 = n_writes;
        first_seen   = 1'b0;
        i_continuous = v.cont;
        run_frame(1'b0, 1'b1, -1, -1, -1);
        for (int f = 0; f < v.n_cap; f++) begin
            if (f == v.n_cap - 1) i_continuous = 1'b0;
            run_frame(1'b1, 1'b0, (f == 0) ? v.inject_line : -1, -1, -1);
        end
        run_frame(1'b0, 1'b0, -1, -1, -1);
        check($sformatf("v%0d_done_count", idx), 32'(n_done - d0), 32'(v.exp_done));
        check($sformatf("v%0d_write_count", idx), 32'(n_writes - w0), 32'(v.exp_writes));
        check($sformatf("v%0d_queue_empty", idx), 32'(exp_q.size()), 32'd0);
        check($sformatf("v%0d_busy_after", idx), 32'(o_busy), 32'd0);
        check($sformatf("v%0d_first_addr", idx), first_addr, 32'(TBASE));
        check($sformatf("v%0d_first_data", idx), 32'(first_data), 32'h0000_00C9);
        check($sformatf("v%0d_last_addr", idx), last_addr, 32'(TBASE + PER_FRAME - 1));
        check($sformatf("v%0d_last_data", idx), 32'(last_data), 32'h0000_0004);
        $display("vector %0d cont=%0d frames=%0d inject=%0d done=%0d writes=%0d",
                 idx, v.cont, v.n_cap, v.inject_line, n_done - d0, n_writes - w0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[3];
        int   d0;
        vecs[0] = '{cont: 1'b0, n_cap: 1, inject_line: -1, exp_done: 1, exp_writes: PER_FRAME};
        vecs[1] = '{cont: 1'b1, n_cap: 3, inject_line: -1, exp_done: 3, exp_writes: 3 * PER_FRAME};
        vecs[2] = '{cont: 1'b0, n_cap: 2, inject_line: 4,  exp_done: 1,
                    exp_writes: (TXMAX - TXMIN + 1) + PER_FRAME};

        vif.i_hsync = 1'b0;
        vif.i_vsync = 1'b0;
        vif.i_blue  = 8'h00;
        repeat (3) @(posedge VGA_CLK_IN);
        #1;
        check("reset_wr_en", 32'(vif.o_wr_en), 32'd0);
        check("reset_wr_addr", vif.o_wr_addr, 32'(TBASE));
        check("reset_wr_data", 32'(vif.o_wr_data), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_frame_done", 32'(o_frame_done), 32'd0);
        check("reset_sync_err", 32'(o_sync_err), 32'd0);
        VGA_RST_N = 1'b1;

        run_frame(1'b0, 1'b0, -1, -1, -1);
        check("idle_no_writes", 32'(n_writes), 32'd0);
        $display("warmup frame writes=%0d", n_writes);

        for (int i = 0; i < 3; i++) begin
            run_vec(vecs[i], i);
        end

        d0 = n_done;
        run_frame(1'b0, 1'b1, -1, -1, -1);
        run_frame(1'b1, 1'b0, -1, 4, -1);
        run_frame(1'b0, 1'b0, -1, -1, -1);
        check("rst_no_done", 32'(n_done - d0), 32'd0);
        check("rst_no_writes_after", 32'(n_writes), 32'(rst_writes));
        check("rst_busy_after", 32'(o_busy), 32'd0);
        check("rst_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("reset sequence done=%0d writes_after_reset=%0d", n_done - d0, n_writes - rst_writes);

        run_vec(vecs[0], 3);

        check("sync_err_before", 32'(o_sync_err), 32'd0);
        run_frame(1'b0, 1'b0, -1, -1, 5);
        check("sync_err_short_line", 32'(o_sync_err), 32'(EXP_SYNC_ERR));
        run_frame(1'b0, 1'b0, -1, -1, -1);
        check("sync_err_sticky", 32'(o_sync_err), 32'(EXP_SYNC_ERR));
        $display("sync check sync_err=%0d", o_sync_err);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
